// File: rtl/usart_rx_controller.sv
// Receive-side controller: handles the 4-phase available/acknowledge handshake
// with usart_rx and buffers received characters in a first-word-fall-through FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for rx_available with enable set; captures on entry to ACK
// ACK   | rx_acknowledge high; waiting for usart_rx to drop rx_available
module usart_rx_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  comm_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_available,
    input  logic                  rx_error,
    output logic                  rx_acknowledge,
    input  logic                  read_strobe,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overrun,
    output logic                  framing_error,
    input  logic                  clear_flags
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_capture;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    r_overrun;
    logic                    r_framing_error;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_char_ok;
    logic                    w_push;
    logic                    w_overrun_set;
    logic                    w_framing_set;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_available && enable) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                // enable is deliberately ignored here so a started handshake always completes
                if (!rx_available) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign rx_acknowledge = (r_state == ST_ACK);

    // ---------------------------------------------------------------- FIFO control
    assign w_full        = (r_count == LP_DEPTH);
    assign w_empty       = (r_count == '0);
    assign w_pop         = read_strobe && !w_empty;
    assign w_char_ok     = w_capture && !rx_error;
    // A full FIFO still accepts the character when the head is popped on the same edge.
    assign w_push        = w_char_ok && (!w_full || w_pop);
    assign w_overrun_set = w_char_ok && w_full && !w_pop;
    assign w_framing_set = w_capture && rx_error;

    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge comm_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign read_data  = r_mem[r_rd_ptr];
    assign read_valid = !w_empty;
    assign fifo_count = r_count;

    // ---------------------------------------------------------------- sticky flags
    // Setting takes priority over clear_flags on the same edge so no event is lost.
    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            r_overrun       <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_framing_set) begin
                r_framing_error <= 1'b1;
            end else if (clear_flags) begin
                r_framing_error <= 1'b0;
            end
        end
    end

    assign overrun       = r_overrun;
    assign framing_error = r_framing_error;

endmodule

// File: tb/tb_usart_rx_controller.sv
// Self-checking bench for usart_rx_controller: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the receive path.
module tb_usart_rx_controller;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          comm_clock;
    logic          reset;
    logic          enable;
    logic [DW-1:0] rx_data;
    logic          rx_available;
    logic          rx_error;
    logic          rx_acknowledge;
    logic          read_strobe;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic [AW:0]   fifo_count;
    logic          overrun;
    logic          framing_error;
    logic          clear_flags;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] m_q[$];
    logic          m_ack;
    logic          m_ov;
    logic          m_fe;

    logic [AW+4:0] w_act;
    assign w_act = {rx_acknowledge, read_valid, fifo_count, overrun, framing_error};

    usart_rx_controller #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .comm_clock    (comm_clock),
        .reset         (reset),
        .enable        (enable),
        .rx_data       (rx_data),
        .rx_available  (rx_available),
        .rx_error      (rx_error),
        .rx_acknowledge(rx_acknowledge),
        .read_strobe   (read_strobe),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .framing_error (framing_error),
        .clear_flags   (clear_flags)
    );

    initial begin
        comm_clock = 1'b0;
        forever #5 comm_clock = ~comm_clock;
    end

    function automatic logic [AW+4:0] exp_status();
        return {m_ack, (m_q.size() != 0), (AW+1)'(m_q.size()), m_ov, m_fe};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ack = 1'b0;
        m_ov  = 1'b0;
        m_fe  = 1'b0;
    endtask

    // Applies the receive rules to the inputs present at the coming edge, then steps the clock.
    task automatic tick();
        bit cap;
        bit ov_set;
        bit fe_set;
        logic [DW-1:0] discard;
        cap    = !m_ack && rx_available && enable;
        ov_set = 1'b0;
        fe_set = 1'b0;
        if (read_strobe && m_q.size() != 0) discard = m_q.pop_front();
        if (cap) begin
            if (rx_error) fe_set = 1'b1;
            else if (m_q.size() < DEPTH) m_q.push_back(rx_data);
            else ov_set = 1'b1;
        end
        if (ov_set) m_ov = 1'b1; else if (clear_flags) m_ov = 1'b0;
        if (fe_set) m_fe = 1'b1; else if (clear_flags) m_fe = 1'b0;
        if (cap) m_ack = 1'b1;
        else if (m_ack && !rx_available) m_ack = 1'b0;
        @(posedge comm_clock);
        #1;
    endtask

    task automatic drive_char(input logic [DW-1:0] d, input logic err);
        rx_data      = d;
        rx_error     = err;
        rx_available = 1'b1;
        tick();
        rx_available = 1'b0;
        rx_error     = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        enable       = 1'b0;
        rx_data      = '0;
        rx_available = 1'b0;
        rx_error     = 1'b0;
        read_strobe  = 1'b0;
        clear_flags  = 1'b0;
        model_reset();
        repeat (2) @(posedge comm_clock);
        #1;
        total++;
        if (w_act !== '0) begin
            $display("FAIL reset_state got=%h want=%h", w_act, {(AW+5){1'b0}});
            bad++;
        end
        reset  = 1'b1;
        enable = 1'b1;
        tick();
        total++;
        if (w_act !== exp_status()) begin
            $display("FAIL reset_release got=%h want=%h", w_act, exp_status());
            bad++;
        end
    endtask

    task automatic test_basic();
        rx_data      = 8'h75;
        rx_available = 1'b1;
        tick();
        total++;
        if (rx_acknowledge !== 1'b1 || fifo_count !== 5'd1 || read_valid !== 1'b1) begin
            $display("FAIL basic_capture got=%h want=%h", w_act, exp_status());
            bad++;
        end
        total++;
        if (read_data !== 8'h75) begin
            $display("FAIL basic_data got=%h want=%h", read_data, 8'h75);
            bad++;
        end
        tick();
        total++;
        if (rx_acknowledge !== 1'b1) begin
            $display("FAIL basic_ack_hold got=%b want=1", rx_acknowledge);
            bad++;
        end
        rx_available = 1'b0;
        tick();
        total++;
        if (w_act !== exp_status() || rx_acknowledge !== 1'b0) begin
            $display("FAIL basic_ack_drop got=%h want=%h", w_act, exp_status());
            bad++;
        end
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        total++;
        if (read_valid !== 1'b0 || fifo_count !== 5'd0) begin
            $display("FAIL basic_pop got=%h want=%h", w_act, exp_status());
            bad++;
        end
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        total++;
        if (fifo_count !== 5'd0) begin
            $display("FAIL basic_underflow got=%0d want=0", fifo_count);
            bad++;
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) drive_char(DW'(i), 1'b0);
        total++;
        if (fifo_count !== 5'd16 || overrun !== 1'b0) begin
            $display("FAIL ovr_fill got=%h want=%h", w_act, exp_status());
            bad++;
        end
        drive_char(8'hAA, 1'b0);
        total++;
        if (fifo_count !== 5'd16 || overrun !== 1'b1 || w_act !== exp_status()) begin
            $display("FAIL ovr_drop got=%h want=%h", w_act, exp_status());
            bad++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (read_data !== DW'(i)) begin
                $display("FAIL ovr_order idx=%0d got=%h want=%h", i, read_data, DW'(i));
                bad++;
            end
            read_strobe = 1'b1;
            tick();
            read_strobe = 1'b0;
        end
        total++;
        if (read_valid !== 1'b0 || overrun !== 1'b1) begin
            $display("FAIL ovr_drain got=%h want=%h", w_act, exp_status());
            bad++;
        end
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        total++;
        if (overrun !== 1'b0 || w_act !== exp_status()) begin
            $display("FAIL ovr_clear got=%h want=%h", w_act, exp_status());
            bad++;
        end
    endtask

    task automatic test_framing();
        drive_char(8'hF7, 1'b1);
        total++;
        if (framing_error !== 1'b1 || fifo_count !== 5'd0 || w_act !== exp_status()) begin
            $display("FAIL fe_set got=%h want=%h", w_act, exp_status());
            bad++;
        end
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        total++;
        if (framing_error !== 1'b0) begin
            $display("FAIL fe_clear got=%b want=0", framing_error);
            bad++;
        end
        rx_data      = 8'hF7;
        rx_error     = 1'b1;
        rx_available = 1'b1;
        clear_flags  = 1'b1;
        tick();
        clear_flags  = 1'b0;
        rx_available = 1'b0;
        rx_error     = 1'b0;
        total++;
        if (framing_error !== 1'b1 || fifo_count !== 5'd0) begin
            $display("FAIL fe_set_wins got=%h want=%h", w_act, exp_status());
            bad++;
        end
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        total++;
        if (w_act !== exp_status()) begin
            $display("FAIL fe_final got=%h want=%h", w_act, exp_status());
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) drive_char(DW'($urandom), 1'b0);
        rx_data      = 8'h55;
        rx_available = 1'b1;
        read_strobe  = 1'b1;
        tick();
        read_strobe  = 1'b0;
        rx_available = 1'b0;
        total++;
        if (fifo_count !== 5'd16 || overrun !== 1'b0 || w_act !== exp_status()) begin
            $display("FAIL full_pushpop got=%h want=%h", w_act, exp_status());
            bad++;
        end
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (read_data !== m_q[0]) begin
                $display("FAIL full_order idx=%0d got=%h want=%h", i, read_data, m_q[0]);
                bad++;
            end
            if (i == DEPTH - 1) begin
                total++;
                if (read_data !== 8'h55) begin
                    $display("FAIL full_last got=%h want=%h", read_data, 8'h55);
                    bad++;
                end
            end
            read_strobe = 1'b1;
            tick();
            read_strobe = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            rx_data      = DW'($urandom);
            rx_available = 1'b1;
            read_strobe  = 1'b1;
            tick();
            rx_available = 1'b0;
            read_strobe  = 1'b0;
            tick();
            total++;
            if (w_act !== exp_status() || read_data !== m_q[0]) begin
                $display("FAIL wrap idx=%0d got=%h/%h want=%h/%h", i, w_act, read_data, exp_status(), m_q[0]);
                bad++;
            end
        end
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic test_enable_reset();
        enable       = 1'b0;
        rx_data      = 8'h3C;
        rx_available = 1'b1;
        repeat (3) tick();
        total++;
        if (rx_acknowledge !== 1'b0 || fifo_count !== 5'd0) begin
            $display("FAIL en_block got=%h want=%h", w_act, exp_status());
            bad++;
        end
        enable = 1'b1;
        tick();
        total++;
        if (rx_acknowledge !== 1'b1 || fifo_count !== 5'd1 || read_data !== 8'h3C) begin
            $display("FAIL en_capture got=%h/%h want=%h/%h", w_act, read_data, exp_status(), 8'h3C);
            bad++;
        end
        enable = 1'b0;
        tick();
        total++;
        if (rx_acknowledge !== 1'b1) begin
            $display("FAIL en_ack_hold got=%b want=1", rx_acknowledge);
            bad++;
        end
        rx_available = 1'b0;
        tick();
        enable = 1'b1;
        drive_char(8'h12, 1'b0);
        drive_char(8'h34, 1'b1);
        rx_data      = 8'h56;
        rx_available = 1'b1;
        tick();
        total++;
        if (rx_acknowledge !== 1'b1 || framing_error !== 1'b1 || w_act !== exp_status()) begin
            $display("FAIL rst_pre got=%h want=%h", w_act, exp_status());
            bad++;
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (w_act !== exp_status()) begin
            $display("FAIL rst_mid_ack got=%h want=%h", w_act, exp_status());
            bad++;
        end
        rx_available = 1'b0;
        reset        = 1'b1;
        tick();
        total++;
        if (w_act !== exp_status()) begin
            $display("FAIL rst_after got=%h want=%h", w_act, exp_status());
            bad++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rx_available = ($urandom_range(0, 1) == 1);
            rx_data      = DW'($urandom);
            rx_error     = ($urandom_range(0, 9) == 0);
            enable       = ($urandom_range(0, 4) != 0);
            clear_flags  = ($urandom_range(0, 15) == 0);
            if (((c / 200) % 2) == 0) read_strobe = ($urandom_range(0, 5) == 0);
            else                      read_strobe = ($urandom_range(0, 1) == 1);
            tick();
            total++;
            if (w_act !== exp_status()) begin
                $display("FAIL rand_status cyc=%0d got=%h want=%h", c, w_act, exp_status());
                bad++;
            end
            if (m_q.size() != 0) begin
                total++;
                if (read_data !== m_q[0]) begin
                    $display("FAIL rand_data cyc=%0d got=%h want=%h", c, read_data, m_q[0]);
                    bad++;
                end
            end
        end
        rx_available = 1'b0;
        rx_error     = 1'b0;
        read_strobe  = 1'b0;
        clear_flags  = 1'b0;
        enable       = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_framing();
        test_back_to_back();
        test_enable_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
